// File: rtl/cvtb_fifo_ctrl_if.sv
// Signal bundle between the FIFO/SRAM buffer controller and its surroundings:
// NetFPGA ingress/egress, processor memory port, buffer RAM control and status.
interface cvtb_fifo_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              in_wr;
  logic              in_first;
  logic              in_last;
  logic              in_rdy;
  logic              out_rdy;
  logic              out_valid;
  logic              out_first;
  logic              out_last;
  logic [ADDR_W-1:0] proc_addr;
  logic              proc_we;
  logic              proc_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_src;
  logic [1:0]        state;
  logic [ADDR_W:0]   pkt_len;
  logic              ovf;

  modport master (
    output in_wr, in_first, in_last, out_rdy, proc_addr, proc_we, proc_done,
    input  in_rdy, out_valid, out_first, out_last, mem_addr, mem_we, mem_src,
           state, pkt_len, ovf
  );

  modport slave (
    input  in_wr, in_first, in_last, out_rdy, proc_addr, proc_we, proc_done,
    output in_rdy, out_valid, out_first, out_last, mem_addr, mem_we, mem_src,
           state, pkt_len, ovf
  );
endinterface

// File: rtl/cvtb_fifo_ctrl.sv
// Sequencer for the convertible FIFO/SRAM packet buffer: receive one packet,
// lend the buffer to the processor, then drain it out in order.
module cvtb_fifo_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  cvtb_fifo_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PROC = 2'd2, DRAIN = 2'd3} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   pkt_len_reg, pkt_len_next;
  logic              ovf_reg, ovf_next;
  logic              in_rdy_reg, in_rdy_next;
  logic              out_valid_reg, out_valid_next;
  logic              out_first_reg, out_first_next;
  logic              out_last_reg, out_last_next;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_src;
  logic              full;
  logic              start;
  logic              issue;

  assign full  = (wr_ptr_reg == DEPTH);
  assign start = bus.in_wr && bus.in_first;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = bus.in_last ? PROC : RECV;
      RECV:  if (bus.in_wr && bus.in_last) state_next = PROC;
      PROC:  if (bus.proc_done) state_next = DRAIN;
      DRAIN: if (out_last_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_src      = 1'b0;
    issue        = 1'b0;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    pkt_len_next = pkt_len_reg;
    ovf_next     = ovf_reg;
    case (state_reg)
      IDLE: begin
        mem_we = start;
        if (start) begin
          wr_ptr_next = ONE;
          ovf_next    = 1'b0;
          if (bus.in_last) pkt_len_next = ONE;
        end
      end
      RECV: begin
        mem_addr = wr_ptr_reg[ADDR_W-1:0];
        mem_we   = bus.in_wr && !full;
        if (bus.in_wr) begin
          if (full) ovf_next = 1'b1;
          else      wr_ptr_next = wr_ptr_reg + ONE;
          // A dropped last word does not count toward the stored length.
          if (bus.in_last) pkt_len_next = full ? DEPTH : wr_ptr_reg + ONE;
        end
      end
      PROC: begin
        mem_addr = bus.proc_addr;
        mem_we   = bus.proc_we;
        mem_src  = 1'b1;
        if (bus.proc_done) rd_ptr_next = '0;
      end
      DRAIN: begin
        mem_addr = rd_ptr_reg[ADDR_W-1:0];
        issue    = bus.out_rdy && (rd_ptr_reg < pkt_len_reg);
        if (issue) rd_ptr_next = rd_ptr_reg + ONE;
      end
      default: ;
    endcase
    // Egress flags line up with the synchronous RAM's one-cycle read latency.
    out_valid_next = issue;
    out_first_next = issue && (rd_ptr_reg == '0);
    out_last_next  = issue && (rd_ptr_reg == pkt_len_reg - ONE);
    in_rdy_next    = (state_next == IDLE) || (state_next == RECV);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      pkt_len_reg   <= '0;
      ovf_reg       <= 1'b0;
      in_rdy_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      pkt_len_reg   <= pkt_len_next;
      ovf_reg       <= ovf_next;
      in_rdy_reg    <= in_rdy_next;
      out_valid_reg <= out_valid_next;
      out_first_reg <= out_first_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_src   = mem_src;
  assign bus.state     = state_reg;
  assign bus.pkt_len   = pkt_len_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.in_rdy    = in_rdy_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_first = out_first_reg;
  assign bus.out_last  = out_last_reg;

endmodule

// File: tb/tb_cvtb_fifo_ctrl.sv
// Directed bench for cvtb_fifo_ctrl with an 8-word buffer RAM model attached.
module tb_cvtb_fifo_ctrl;

  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] in_data = '0;
  logic [71:0] proc_wdata = '0;
  logic [71:0] rd_data;
  logic [71:0] ram [0:(1<<AW)-1];
  int          wr_count = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          base;

  cvtb_fifo_ctrl_if #(.ADDR_W(AW)) bus();

  cvtb_fifo_ctrl #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_src ? proc_wdata : in_data;
      wr_count <= wr_count + 1;
    end
    rd_data <= ram[bus.mem_addr];
  end

  function automatic logic [71:0] wv(input int k);
    logic [7:0] ctrl;
    ctrl = (k == 0) ? 8'hFF : 8'h00;
    return {ctrl, 64'h100 + 64'(k)};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_wr = 0; bus.in_first = 0; bus.in_last = 0; bus.out_rdy = 0;
    bus.proc_addr = '0; bus.proc_we = 0; bus.proc_done = 0;

    // Asynchronous reset before the first clock edge
    #2 rst = 1'b0;
    #2;
    chk("rst_state", bus.state, 0);
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_pkt_len", bus.pkt_len, 0);
    chk("rst_ovf", bus.ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("idle_in_rdy", bus.in_rdy, 1);

    // Packet 1: four words, drained with out_rdy held high
    base = wr_count;
    for (int k = 0; k < 4; k++) begin
      bus.in_wr = 1; bus.in_first = (k == 0); bus.in_last = (k == 3); in_data = wv(k);
      #1;
      chk("p1_mem_we", bus.mem_we, 1);
      chk("p1_mem_addr", bus.mem_addr, k);
      chk("p1_mem_src", bus.mem_src, 0);
      tick();
      if (k < 3) chk("p1_recv_state", bus.state, 1);
    end
    bus.in_wr = 0; bus.in_first = 0; bus.in_last = 0;
    chk("p1_proc_state", bus.state, 2);
    chk("p1_pkt_len", bus.pkt_len, 4);
    chk("p1_in_rdy", bus.in_rdy, 0);
    chk("p1_writes", wr_count - base, 4);
    repeat (3) tick();
    bus.out_rdy = 1; bus.proc_done = 1;
    tick();
    bus.proc_done = 0;
    chk("p1_drain_state", bus.state, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p1_out_valid", bus.out_valid, 1);
      chk("p1_out_first", bus.out_first, (i == 0));
      chk("p1_out_last", bus.out_last, (i == 3));
      chk("p1_out_data", rd_data, wv(i));
    end
    tick();
    chk("p1_end_state", bus.state, 0);
    chk("p1_end_in_rdy", bus.in_rdy, 1);
    chk("p1_end_valid", bus.out_valid, 0);
    $display("packet 1: 4 words received and drained");

    // Packet 2: single word with first and last together
    bus.in_wr = 1; bus.in_first = 1; bus.in_last = 1; in_data = 72'hFF_0000_0000_0000_00AA;
    tick();
    bus.in_wr = 0; bus.in_first = 0; bus.in_last = 0;
    chk("p2_state", bus.state, 2);
    chk("p2_pkt_len", bus.pkt_len, 1);
    bus.proc_done = 1;
    tick();
    bus.proc_done = 0;
    chk("p2_drain_state", bus.state, 3);
    tick();
    chk("p2_out_valid", bus.out_valid, 1);
    chk("p2_out_first", bus.out_first, 1);
    chk("p2_out_last", bus.out_last, 1);
    chk("p2_out_data", rd_data, 72'hFF_0000_0000_0000_00AA);
    tick();
    chk("p2_end_state", bus.state, 0);
    $display("packet 2: single word received and drained");

    // Packet 3: ten words into an eight-word buffer
    base = wr_count;
    for (int k = 0; k < 10; k++) begin
      bus.in_wr = 1; bus.in_first = (k == 0); bus.in_last = (k == 9); in_data = wv(k);
      #1;
      chk("p3_mem_we", bus.mem_we, (k < 8));
      tick();
    end
    bus.in_wr = 0; bus.in_first = 0; bus.in_last = 0;
    chk("p3_state", bus.state, 2);
    chk("p3_pkt_len", bus.pkt_len, 8);
    chk("p3_ovf", bus.ovf, 1);
    chk("p3_writes", wr_count - base, 8);

    // Processor overwrites word 2 while ingress keeps pulsing
    bus.proc_addr = 3'd2; bus.proc_we = 1; proc_wdata = 72'hAB;
    bus.in_wr = 1; bus.in_first = 1;
    #1;
    chk("p3_proc_src", bus.mem_src, 1);
    chk("p3_proc_we", bus.mem_we, 1);
    chk("p3_proc_addr", bus.mem_addr, 2);
    tick();
    bus.proc_we = 0;
    base = wr_count;
    tick();
    tick();
    chk("p3_proc_in_wr_ignored", wr_count - base, 0);
    chk("p3_proc_hold", bus.state, 2);
    bus.in_wr = 0; bus.in_first = 0;

    // Drain with out_rdy pattern 1,0,1,1,...
    bus.out_rdy = 1; bus.proc_done = 1;
    tick();
    bus.proc_done = 0;
    chk("p3_drain_state", bus.state, 3);
    chk("p3_valid_d0", bus.out_valid, 0);
    tick();
    chk("p3_valid_d1", bus.out_valid, 1);
    chk("p3_first_d1", bus.out_first, 1);
    chk("p3_data_w0", rd_data, wv(0));
    bus.out_rdy = 0;
    #1;
    chk("p3_addr_stall", bus.mem_addr, 1);
    chk("p3_drain_no_we", bus.mem_we, 0);
    tick();
    chk("p3_valid_d2", bus.out_valid, 0);
    chk("p3_addr_hold", bus.mem_addr, 1);
    bus.out_rdy = 1;
    tick();
    chk("p3_valid_d3", bus.out_valid, 1);
    chk("p3_first_w1", bus.out_first, 0);
    chk("p3_data_w1", rd_data, wv(1));
    tick();
    chk("p3_valid_d4", bus.out_valid, 1);
    chk("p3_data_w2_proc", rd_data, 72'hAB);
    for (int j = 3; j < 8; j++) begin
      tick();
      chk("p3_valid_tail", bus.out_valid, 1);
      chk("p3_data_tail", rd_data, wv(j));
      chk("p3_last_tail", bus.out_last, (j == 7));
    end
    tick();
    chk("p3_end_state", bus.state, 0);
    chk("p3_end_valid", bus.out_valid, 0);
    $display("packet 3: 10 words offered, 8 stored, processor write at 2, drained");

    // Packet 4: a new packet clears ovf; reset lands mid-drain
    bus.in_wr = 1; bus.in_first = 1; bus.in_last = 0; in_data = wv(0);
    tick();
    chk("p4_ovf_clear", bus.ovf, 0);
    chk("p4_recv_state", bus.state, 1);
    bus.in_first = 0; bus.in_last = 1; in_data = wv(1);
    tick();
    bus.in_wr = 0; bus.in_last = 0;
    chk("p4_state", bus.state, 2);
    chk("p4_pkt_len", bus.pkt_len, 2);
    bus.proc_done = 1;
    tick();
    bus.proc_done = 0;
    tick();
    chk("p4_valid_before_rst", bus.out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("p4_rst_state", bus.state, 0);
    chk("p4_rst_valid", bus.out_valid, 0);
    chk("p4_rst_first", bus.out_first, 0);
    chk("p4_rst_in_rdy", bus.in_rdy, 0);
    chk("p4_rst_pkt_len", bus.pkt_len, 0);
    chk("p4_rst_mem_we", bus.mem_we, 0);
    @(negedge clk) rst = 1'b1;
    bus.in_wr = 1; bus.in_first = 0; bus.in_last = 0;
    base = wr_count;
    #1;
    chk("p4_nofirst_we", bus.mem_we, 0);
    tick();
    tick();
    chk("p4_nofirst_writes", wr_count - base, 0);
    chk("p4_nofirst_state", bus.state, 0);
    bus.in_wr = 0;
    $display("packet 4: ovf cleared, reset mid-drain, stray word ignored");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
